arcade_input_mapper: RTL and testbench

- Parametrised control-mapping block between hps_io joystick words and an arcade core's active-low player inputs.
- Generalises the fixed two-player, OR-shared mapping to N players and M buttons.
- Modes: shared (all sticks OR'd, the legacy behaviour) or independent (stick p drives player p).
- Adds coin pulse shaping with lockout, and per-button frame-synchronous autofire.

---
 rtl/arcade_input_pkg.sv | 26 ++
 rtl/arcade_coin_shaper.sv | 90 +++++++++
 rtl/arcade_input_mapper.sv | 159 +++++++++++++++
 tb/tb_arcade_input_mapper.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/arcade_input_pkg.sv
// Shared constants and types for the arcade input mapper.
// The joystick word layout is fixed for bits 0..4. The start, start-2P and
// coin bits move up as the button count grows.
package arcade_input_pkg;

    // Fixed bit positions inside a 16-bit hps_io joystick word
    localparam int JB_RIGHT = 0;
    localparam int JB_LEFT  = 1;
    localparam int JB_DOWN  = 2;
    localparam int JB_UP    = 3;
    localparam int JB_BTN0  = 4;

    // Start bit position for a given button count.
    // Start-2P sits at +1 and coin sits at +2.
    function automatic int jb_start(input int nb);
        return JB_BTN0 + nb;
    endfunction

    // Coin pulse shaper states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2
    } coin_state_t;

endpackage

// File: rtl/arcade_coin_shaper.sv
// Single-player coin pulse shaper.
// A rising edge of src produces one active-low pulse of COIN_PULSE cycles.
// A lockout gap of COIN_GAP cycles follows the pulse. A COIN_GAP of 0 still
// holds the lockout for one cycle. Edge detection is registered, so there is
// one cycle between src and the state change.
module arcade_coin_shaper
    import arcade_input_pkg::*;
#(
    parameter logic [15:0] COIN_PULSE = 16'd4096,
    parameter logic [15:0] COIN_GAP   = 16'd8192
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic src,
    output logic coin_n
);

    // Terminal counts. A zero length collapses to a single cycle.
    localparam logic [15:0] PULSE_LAST = (COIN_PULSE == 16'd0) ? 16'd0 : COIN_PULSE - 16'd1;
    localparam logic [15:0] GAP_LAST   = (COIN_GAP == 16'd0)   ? 16'd0 : COIN_GAP - 16'd1;

    coin_state_t state_reg, state_next;
    logic [15:0] cnt_reg, cnt_next;
    logic        prev_reg;
    logic        rise_reg;
    logic        coin_n_reg;

    // Registered edge detector. prev resets high, so a coin held through
    // reset never looks like a fresh insertion.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            prev_reg <= 1'b1;
            rise_reg <= 1'b0;
        end else begin
            prev_reg <= src;
            rise_reg <= src & ~prev_reg;
        end
    end

    // State, counter and output register
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_reg  <= IDLE;
            cnt_reg    <= 16'd0;
            coin_n_reg <= 1'b1;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            coin_n_reg <= (state_next != PULSE);
        end
    end

    // Next-state logic: IDLE -> PULSE on an edge, PULSE -> GAP -> IDLE on terminal counts.
    // Edges seen during GAP are dropped.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (rise_reg) begin
                    state_next = PULSE;
                    cnt_next   = 16'd0;
                end
            end
            PULSE: begin
                if (cnt_reg == PULSE_LAST) begin
                    state_next = GAP;
                    cnt_next   = 16'd0;
                end else begin
                    cnt_next = cnt_reg + 16'd1;
                end
            end
            GAP: begin
                if (cnt_reg == GAP_LAST) begin
                    state_next = IDLE;
                    cnt_next   = 16'd0;
                end else begin
                    cnt_next = cnt_reg + 16'd1;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = 16'd0;
            end
        endcase
    end

    assign coin_n = coin_n_reg;

endmodule

// File: rtl/arcade_input_mapper.sv
// Maps hps_io joystick words onto an arcade core's active-low player inputs.
// There are N players with M buttons each.
// - Shared mode ORs all sticks together onto every player.
// - Independent mode routes stick p to player p.
// Coins are pulse-shaped per player. Buttons can autofire in step with vblank.
module arcade_input_mapper
    import arcade_input_pkg::*;
#(
    parameter int          NUM_PLAYERS = 2,
    parameter int          NUM_BUTTONS = 2,
    parameter logic [15:0] COIN_PULSE  = 16'd4096,
    parameter logic [15:0] COIN_GAP    = 16'd8192,
    parameter int          AF_FRAMES   = 4
) (
    input  logic                               clk_sys,
    input  logic                               reset,
    input  logic [16*NUM_PLAYERS-1:0]          joy_in,
    input  logic                               share,
    input  logic [NUM_BUTTONS-1:0]             af_en,
    input  logic                               vblank,
    output logic [NUM_PLAYERS-1:0]             up_n,
    output logic [NUM_PLAYERS-1:0]             down_n,
    output logic [NUM_PLAYERS-1:0]             left_n,
    output logic [NUM_PLAYERS-1:0]             right_n,
    output logic [NUM_PLAYERS*NUM_BUTTONS-1:0] btn_n,
    output logic [NUM_PLAYERS-1:0]             start_n,
    output logic [NUM_PLAYERS-1:0]             coin_n
);

    localparam int JB_S     = jb_start(NUM_BUTTONS);
    localparam int JB_S2    = JB_S + 1;
    localparam int JB_COIN  = JB_S + 2;
    localparam logic [3:0] AF_LAST = (AF_FRAMES > 1) ? 4'(AF_FRAMES - 1) : 4'd0;

    // Stage 0 input registers
    logic [16*NUM_PLAYERS-1:0] joy_s0_reg;
    logic                      share_s0_reg;
    logic                      vblank_s0_reg;
    logic                      vblank_prev_reg;

    // Autofire frame counter and phase
    logic [3:0] af_cnt_reg;
    logic       af_phase_reg;
    logic       frame_tick;

    logic [15:0] joy_or;

    // Stage 0 capture. These are plain pipeline registers and are not reset.
    // They keep tracking the inputs during reset, so a coin held through
    // reset stays high and is never mistaken for a new press.
    always_ff @(posedge clk_sys) begin
        joy_s0_reg      <= joy_in;
        share_s0_reg    <= share;
        vblank_s0_reg   <= vblank;
        vblank_prev_reg <= vblank_s0_reg;
    end

    // OR of every stick. Used by shared mode, start-2P and the shared coin.
    always_comb begin
        joy_or = 16'd0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            joy_or = joy_or | joy_s0_reg[16*p +: 16];
        end
    end

    assign frame_tick = vblank_s0_reg & ~vblank_prev_reg;

    // Autofire timebase. The phase flips every AF_FRAMES frame ticks and
    // starts in the firing half after reset.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            af_cnt_reg   <= 4'd0;
            af_phase_reg <= 1'b1;
        end else if (frame_tick) begin
            if (af_cnt_reg == AF_LAST) begin
                af_cnt_reg   <= 4'd0;
                af_phase_reg <= ~af_phase_reg;
            end else begin
                af_cnt_reg <= af_cnt_reg + 4'd1;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PLAYERS; gi++) begin : g_player
            logic [15:0]            eff;
            logic                   start_act;
            logic                   coin_src;
            logic                   unused_eff;
            logic                   right_reg, left_reg, down_reg, up_reg, start_reg;
            logic [NUM_BUTTONS-1:0] btn_reg, btn_next;

            assign eff = share_s0_reg ? joy_or : joy_s0_reg[16*gi +: 16];

            // Player 1 also answers the start-2P bit of any stick
            if (gi == 1) begin : g_start_p1
                assign start_act = eff[JB_S] | joy_or[JB_S2];
            end else begin : g_start_pn
                assign start_act = eff[JB_S];
            end

            // In shared mode only player 0 sees coins. It takes them from any stick.
            if (gi == 0) begin : g_coin_p0
                assign coin_src = share_s0_reg ? joy_or[JB_COIN] : eff[JB_COIN];
            end else begin : g_coin_pn
                assign coin_src = share_s0_reg ? 1'b0 : eff[JB_COIN];
            end

            // Upper joystick bits have no function at small button counts
            assign unused_eff = ^eff;

            // Buttons: an autofire-enabled button only reports pressed in the firing phase
            always_comb begin
                btn_next = '1;
                for (int b = 0; b < NUM_BUTTONS; b++) begin
                    btn_next[b] = ~(eff[JB_BTN0 + b] & (~af_en[b] | af_phase_reg));
                end
            end

            // Registered active-low player outputs
            always_ff @(posedge clk_sys) begin
                if (reset) begin
                    right_reg <= 1'b1;
                    left_reg  <= 1'b1;
                    down_reg  <= 1'b1;
                    up_reg    <= 1'b1;
                    start_reg <= 1'b1;
                    btn_reg   <= '1;
                end else begin
                    right_reg <= ~eff[JB_RIGHT];
                    left_reg  <= ~eff[JB_LEFT];
                    down_reg  <= ~eff[JB_DOWN];
                    up_reg    <= ~eff[JB_UP];
                    start_reg <= ~start_act;
                    btn_reg   <= btn_next;
                end
            end

            assign right_n[gi] = right_reg;
            assign left_n[gi]  = left_reg;
            assign down_n[gi]  = down_reg;
            assign up_n[gi]    = up_reg;
            assign start_n[gi] = start_reg;
            assign btn_n[gi*NUM_BUTTONS +: NUM_BUTTONS] = btn_reg;

            arcade_coin_shaper #(
                .COIN_PULSE (COIN_PULSE),
                .COIN_GAP   (COIN_GAP)
            ) u_coin (
                .clk_sys (clk_sys),
                .reset   (reset),
                .src     (coin_src),
                .coin_n  (coin_n[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_arcade_input_mapper.sv
// Scoreboard bench for arcade_input_mapper.
// The driver applies one input set per cycle. It pushes the expected outputs
// for the next clock edge, which it derives from the input history. A separate
// monitor pops one expectation per clock and compares.
module tb_arcade_input_mapper;

    localparam int NP = 2;
    localparam int NB = 2;
    localparam int CP = 4;
    localparam int CG = 6;
    localparam int AF = 2;
    localparam int S  = 4 + NB;

    logic                 clk_sys = 1'b0;
    logic                 reset   = 1'b1;
    logic [16*NP-1:0]     joy_in  = '0;
    logic                 share   = 1'b1;
    logic [NB-1:0]        af_en   = '0;
    logic                 vblank  = 1'b0;
    logic [NP-1:0]        up_n, down_n, left_n, right_n, start_n, coin_n;
    logic [NP*NB-1:0]     btn_n;

    arcade_input_mapper #(
        .NUM_PLAYERS (NP),
        .NUM_BUTTONS (NB),
        .COIN_PULSE  (16'(CP)),
        .COIN_GAP    (16'(CG)),
        .AF_FRAMES   (AF)
    ) dut (
        .clk_sys (clk_sys),
        .reset   (reset),
        .joy_in  (joy_in),
        .share   (share),
        .af_en   (af_en),
        .vblank  (vblank),
        .up_n    (up_n),
        .down_n  (down_n),
        .left_n  (left_n),
        .right_n (right_n),
        .btn_n   (btn_n),
        .start_n (start_n),
        .coin_n  (coin_n)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        logic             rst;
        logic [16*NP-1:0] joy;
        logic             shr;
        logic             vb;
        logic [NB-1:0]    af;
    } stim_t;

    typedef struct {
        logic [NP-1:0]    up, down, left, right, start, coin;
        logic [NP*NB-1:0] btn;
    } exp_t;

    stim_t hist[$];
    exp_t  exp_q[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc    = 0;

    // Reference model state, kept in terms of the spec's own rules:
    //   nticks       - frame ticks seen since reset
    //   low_until[p] - last model step at which coin p is pulsing
    //   block_until  - last model step at which coin p is busy (pulse or lockout)
    int nticks = 0;
    int low_until[NP];
    int block_until[NP];

    logic             cur_rst = 1'b1;
    logic [16*NP-1:0] cur_joy = '0;
    logic             cur_shr = 1'b1;
    logic             cur_vb  = 1'b0;
    logic [NB-1:0]    cur_af  = '0;

    function automatic logic coin_src(input stim_t x, input int p);
        logic any;
        any = 1'b0;
        for (int q = 0; q < NP; q++) any = any | x.joy[16*q + S + 2];
        if (x.shr) return (p == 0) ? any : 1'b0;
        return x.joy[16*p + S + 2];
    endfunction

    // Expected outputs after the clock edge that samples the newest stimulus.
    // Directions, buttons and start come from the stimulus one cycle back.
    // Coin edges come from the stimulus two and three cycles back.
    task automatic model_step(input stim_t x);
        stim_t x1, x2, x3;
        exp_t  e;
        logic [15:0] or_all, eff;
        logic  phase, s2, s3, rise;
        int    t;
        hist.push_back(x);
        t  = hist.size() - 1;
        x1 = hist[t-1];
        x2 = hist[t-2];
        x3 = hist[t-3];
        e.up = '1; e.down = '1; e.left = '1; e.right = '1;
        e.start = '1; e.coin = '1; e.btn = '1;
        if (x.rst) begin
            nticks = 0;
            for (int p = 0; p < NP; p++) begin
                low_until[p]   = -1;
                block_until[p] = -1;
            end
        end else begin
            phase  = ((nticks / AF) % 2) == 0;
            or_all = '0;
            for (int p = 0; p < NP; p++) or_all = or_all | x1.joy[16*p +: 16];
            for (int p = 0; p < NP; p++) begin
                eff = x1.shr ? or_all : x1.joy[16*p +: 16];
                e.right[p] = ~eff[0];
                e.left[p]  = ~eff[1];
                e.down[p]  = ~eff[2];
                e.up[p]    = ~eff[3];
                for (int b = 0; b < NB; b++)
                    e.btn[p*NB+b] = ~(eff[4+b] & (~x.af[b] | phase));
                e.start[p] = ~(eff[S] | ((p == 1) ? or_all[S+1] : 1'b0));
                s2   = coin_src(x2, p);
                s3   = coin_src(x3, p);
                rise = !x1.rst && s2 && !(x2.rst || s3);
                if (t > block_until[p] && rise) begin
                    low_until[p]   = t + CP - 1;
                    block_until[p] = t + CP + ((CG == 0) ? 1 : CG);
                end
                e.coin[p] = !(t <= low_until[p]);
            end
            if (x1.vb && !x2.vb) nticks++;
        end
        exp_q.push_back(e);
    endtask

    task automatic drive();
        stim_t x;
        @(negedge clk_sys);
        reset  = cur_rst;
        joy_in = cur_joy;
        share  = cur_shr;
        vblank = cur_vb;
        af_en  = cur_af;
        x.rst = cur_rst; x.joy = cur_joy; x.shr = cur_shr; x.vb = cur_vb; x.af = cur_af;
        model_step(x);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) drive();
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d: got %b expected %b", name, cyc, act, exp);
        end
    endtask

    // Monitor: one expectation per clock edge, sampled after the edge
    initial begin
        forever begin
            exp_t e;
            @(posedge clk_sys);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                cyc++;
                $display("cyc %0d up=%b dn=%b lf=%b rt=%b btn=%b start=%b coin=%b", cyc,
                         up_n, down_n, left_n, right_n, btn_n, start_n, coin_n);
                check("up_n",    8'(up_n),    8'(e.up));
                check("down_n",  8'(down_n),  8'(e.down));
                check("left_n",  8'(left_n),  8'(e.left));
                check("right_n", 8'(right_n), 8'(e.right));
                check("btn_n",   8'(btn_n),   8'(e.btn));
                check("start_n", 8'(start_n), 8'(e.start));
                check("coin_n",  8'(coin_n),  8'(e.coin));
            end
        end
    end

    initial begin
        stim_t init;
        int    waited;
        init.rst = 1'b1; init.joy = '0; init.shr = 1'b1; init.vb = 1'b0; init.af = '0;
        for (int i = 0; i < 3; i++) hist.push_back(init);
        for (int p = 0; p < NP; p++) begin
            low_until[p]   = -1;
            block_until[p] = -1;
        end

        // Reset, then shared mode with button 0 on stick 1
        cur_rst = 1'b1; cur_shr = 1'b1; cur_joy = '0;
        run(4);
        cur_rst = 1'b0; cur_joy = 32'h0010_0000;
        run(4);

        // Independent mode: up on stick 0, right on stick 1
        cur_shr = 1'b0; cur_joy = 32'h0001_0008;
        run(4);

        // Coin held long: exactly one pulse
        cur_joy = '0;
        run(3);
        cur_joy = 32'h0000_0100;
        run(40);
        cur_joy = '0;
        run(5);
        // Short press, then a second press that lands in the lockout gap
        cur_joy = 32'h0000_0100; run(3);
        cur_joy = '0;            run(2);
        cur_joy = 32'h0000_0100; run(5);
        cur_joy = '0;            run(10);
        // Press after the gap: new pulse
        cur_joy = 32'h0000_0100; run(8);
        cur_joy = '0;            run(12);

        // Autofire on button 0 only, both buttons held, vblank every 4 cycles
        cur_af = 2'b01; cur_joy = 32'h0000_0030;
        for (int i = 0; i < 12; i++) begin
            cur_vb = 1'b1; run(1);
            cur_vb = 1'b0; run(3);
        end
        cur_af = '0; cur_joy = '0;
        run(3);

        // Shared mode: start-2P and coin on stick 1
        cur_shr = 1'b1; cur_joy = 32'h0180_0000;
        run(20);
        cur_joy = '0;
        run(15);

        // Reset in the middle of a pulse with the coin still held
        cur_shr = 1'b0; cur_joy = 32'h0000_0100;
        run(5);
        cur_rst = 1'b1; run(2);
        cur_rst = 1'b0; run(20);
        cur_joy = '0;   run(12);

        // Randomized traffic
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 3) == 0)
                for (int p = 0; p < NP; p++) cur_joy[16*p +: 16] = 16'($urandom & $urandom);
            if ($urandom_range(0, 31) == 0) cur_shr = ~cur_shr;
            if ($urandom_range(0, 15) == 0) cur_af = NB'($urandom);
            if ($urandom_range(0, 4) == 0)  cur_vb = ~cur_vb;
            cur_rst = ($urandom_range(0, 99) == 0);
            drive();
        end
        cur_rst = 1'b0;

        // Let the monitor drain the scoreboard, bounded
        waited = 0;
        while (exp_q.size() > 0 && waited < 20) begin
            @(posedge clk_sys);
            waited++;
        end
        #2;
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
